crc_seq_ctrl: RTL and testbench

//  Sequencer that drives a combinational CRC step over a stream of WDATA-bit words, WCODE bits per clock.

---
 rtl/crc_ctrl_pkg.sv | 21 ++
 rtl/crc_step.sv | 35 +++
 rtl/crc_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_crc_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_ctrl_pkg.sv
// rtl/crc_ctrl_pkg.sv - shared types and helpers for the CRC sequencer
package crc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } crc_state_t;

    // Number of WCODE-bit chunks folded per WDATA-bit word.
    function automatic int calc_nchunk(input int wdata, input int wcode);
        return wdata / wcode;
    endfunction

    // Counter width for 0..nchunk-1, never narrower than one bit.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/crc_step.sv
// rtl/crc_step.sv - combinational fold of one WCODE-bit chunk into a CRC remainder
//
// Ports:
//   crc      in   WPOLY-1  current remainder
//   poly     in   WPOLY    generator polynomial including its MSB
//   chunk    in   WCODE    data chunk, folded MSB-first
//   crc_next out  WPOLY-1  (crc*x^WCODE xor chunk*x^(WPOLY-1)) mod poly
module crc_step #(
    parameter int WCODE = 4,
    parameter int WPOLY = 9
) (
    input  logic [WPOLY-2:0] crc,
    input  logic [WPOLY-1:0] poly,
    input  logic [WCODE-1:0] chunk,
    output logic [WPOLY-2:0] crc_next
);

    logic [WPOLY-2:0] rem;
    logic [WPOLY-1:0] ext;

    always_comb begin
        rem = crc;
        ext = '0;
        for (int i = WCODE - 1; i >= 0; i--) begin
            // Shift into the full polynomial width; the bit that falls off the
            // top, combined with the incoming data bit, decides the reduction.
            // With a proper poly (MSB set) the top bit of ext clears to zero.
            ext = {rem, 1'b0};
            ext = ext ^ (poly & {WPOLY{ext[WPOLY-1] ^ chunk[i]}});
            rem = ext[WPOLY-2:0];
        end
        crc_next = rem;
    end

endmodule

// File: rtl/crc_seq_ctrl.sv
// rtl/crc_seq_ctrl.sv - valid/ready sequencer running a chunked CRC over a word stream
//
// Optional feature macro: CRC_CHECK_EN (adds i_crc_exp / o_crc_err compare).
//
// Ports:
//   i_clk, i_rstn      clock (rising edge), synchronous active-low reset
//   i_start            begin a new frame: latch i_poly, load CRC_INIT (aborts any frame)
//   i_poly             generator polynomial including MSB
//   i_data/i_valid     word input; i_last marks the final word of the frame
//   o_ready            word accepted on cycles with i_valid & o_ready
//   o_busy             frame in progress
//   o_done             one-cycle pulse when o_crc is final
//   o_crc              running / final remainder
//   i_crc_exp          expected CRC (CRC_CHECK_EN only)
//   o_crc_err          final CRC mismatch, held until i_start (CRC_CHECK_EN only)
module crc_seq_ctrl
    import crc_ctrl_pkg::*;
#(
    parameter int               WDATA    = 8,
    parameter int               WCODE    = 4,
    parameter int               WPOLY    = 9,
    parameter logic [WPOLY-2:0] CRC_INIT = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [WPOLY-1:0] i_poly,
    input  logic [WDATA-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WPOLY-2:0] o_crc
`ifdef CRC_CHECK_EN
    ,
    input  logic [WPOLY-2:0] i_crc_exp,
    output logic             o_crc_err
`endif
);

    localparam int NCHUNK = calc_nchunk(WDATA, WCODE);
    localparam int CNT_W  = calc_cnt_w(NCHUNK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    crc_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WDATA-1:0] word_q;
    logic             last_q;
    logic [WPOLY-1:0] poly_q;
    logic [WPOLY-2:0] crc_q, crc_next;
    logic             load, accept, shift_en;

    crc_step #(
        .WCODE(WCODE),
        .WPOLY(WPOLY)
    ) u_step (
        .crc     (crc_q),
        .poly    (poly_q),
        .chunk   (word_q[WDATA-1 -: WCODE]),
        .crc_next(crc_next)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        shift_en   = 1'b0;
        // i_start takes priority everywhere, so a word offered alongside it is dropped.
        if (i_start) begin
            load       = 1'b1;
            state_next = RUN;
        end else begin
            case (state)
                IDLE:  state_next = IDLE;
                RUN: begin
                    if (i_valid) begin
                        accept     = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    shift_en = 1'b1;
                    if (cnt == CNT_LAST) state_next = last_q ? DONE : RUN;
                end
                DONE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt    <= '0;
            word_q <= '0;
            last_q <= 1'b0;
            poly_q <= '0;
            crc_q  <= '0;
        end else begin
            if (load) begin
                crc_q  <= CRC_INIT;
                poly_q <= i_poly;
                cnt    <= '0;
            end
            if (accept) begin
                word_q <= i_data;
                last_q <= i_last;
                cnt    <= '0;
            end
            if (shift_en) begin
                crc_q  <= crc_next;
                // Next chunk is always taken from the top of the word register.
                word_q <= word_q << WCODE;
                cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

`ifdef CRC_CHECK_EN
    logic crc_err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn)             crc_err_q <= 1'b0;
        else if (load)           crc_err_q <= 1'b0;
        else if (state == DONE)  crc_err_q <= (crc_q != i_crc_exp);
    end

    assign o_crc_err = crc_err_q;
`endif

    assign o_ready = (state == RUN);
    assign o_busy  = (state != IDLE);
    assign o_done  = (state == DONE);
    assign o_crc   = crc_q;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// tb/tb_crc_seq_ctrl.sv - directed self-checking bench for crc_seq_ctrl
module tb_crc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rstn, start, valid, last;
    logic [8:0] poly;
    logic [7:0] data;
    logic       ready, busy, done;
    logic [7:0] crc;
`ifdef CRC_CHECK_EN
    logic [7:0] crc_exp;
    logic       crc_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int snap;
    logic [7:0] msg [9];
    logic rdy_log [27];

    always #5 clk = ~clk;

    crc_seq_ctrl dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_start  (start),
        .i_poly   (poly),
        .i_data   (data),
        .i_valid  (valid),
        .i_last   (last),
        .o_ready  (ready),
        .o_busy   (busy),
        .o_done   (done),
        .o_crc    (crc)
`ifdef CRC_CHECK_EN
        ,
        .i_crc_exp(crc_exp),
        .o_crc_err(crc_err)
`endif
    );

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [8:0] p);
        @(negedge clk);
        start = 1'b1;
        poly  = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic l, input bit drop);
        int n;
        n = 0;
        data  = d;
        last  = l;
        valid = 1'b1;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (drop) valid = 1'b0;
    endtask

    task automatic send_msg(input int from, input int upto, input bit drop);
        for (int i = from; i <= upto; i++) send_word(msg[i], (i == 8), drop);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int idx, bad;
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        rstn = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
        poly = 9'h107; data = 8'h00;
`ifdef CRC_CHECK_EN
        crc_exp = 8'h00;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {21'd0, ready, busy, done, crc}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_outs", {21'd0, ready, busy, done, crc}, 32'd0);

        // Case 1: "123456789" -> F4; poly change mid-frame ignored
        do_start(9'h107);
        check("t1_ready", {31'd0, ready}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        poly = 9'h11D;
        snap = done_cnt;
        send_msg(0, 8, 1'b1);
        wait_done("t1_done");
        check("t1_crc", {24'd0, crc}, 32'hF4);
        @(negedge clk);
        check("t1_done_once", done_cnt - snap, 32'd1);
        check("t1_idle_hold", {22'd0, busy, done, crc}, 32'hF4);

        // Case 2: single word 0x01, o_done two edges after accept edge
        do_start(9'h107);
        data = 8'h01; last = 1'b1; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("t2_done_k", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("t2_done_k1", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("t2_done_k2", {31'd0, done}, 32'd1);
        check("t2_crc", {24'd0, crc}, 32'h07);
        @(negedge clk);
        check("t2_after", {22'd0, busy, done, crc}, 32'h07);

        // Case 3: valid held high, ready pattern 1,0,0 per word
        do_start(9'h107);
        snap = done_cnt;
        idx = 0;
        valid = 1'b1;
        for (int c = 0; c < 27; c++) begin
            rdy_log[c] = ready;
            if (ready && idx < 9) begin
                data = msg[idx];
                last = (idx == 8);
                idx++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        bad = 0;
        for (int c = 0; c < 27; c++) if (rdy_log[c] !== ((c % 3) == 0)) bad++;
        check("t3_ready_pattern", bad, 32'd0);
        check("t3_words", idx, 32'd9);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_crc", {24'd0, crc}, 32'hF4);
        @(negedge clk);
        check("t3_done_once", done_cnt - snap, 32'd1);

        // Case 4: abort after 4 words, word offered with i_start dropped, then full frame
        do_start(9'h107);
        snap = done_cnt;
        send_msg(0, 3, 1'b1);
        @(negedge clk);
        start = 1'b1; valid = 1'b1; data = 8'hAA; last = 1'b1;
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
        check("t4_offer_dropped", {30'd0, ready, done}, 32'd2);
        check("t4_crc_reload", {24'd0, crc}, 32'h00);
        check("t4_no_done_abort", done_cnt - snap, 32'd0);
        send_msg(0, 8, 1'b1);
        wait_done("t4_done");
        check("t4_crc", {24'd0, crc}, 32'hF4);
        @(negedge clk);
        check("t4_done_once", done_cnt - snap, 32'd1);

        // Case 5: reset mid-SHIFT
        do_start(9'h107);
        send_word(8'h31, 1'b0, 1'b1);
        check("t5_in_shift", {30'd0, ready, busy}, 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("t5_reset_outs", {21'd0, ready, busy, done, crc}, 32'd0);
        rstn = 1'b1;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_stay_idle", {30'd0, ready, busy}, 32'd0);
        valid = 1'b0;
        do_start(9'h107);
        check("t5_ready_after_start", {31'd0, ready}, 32'd1);

`ifdef CRC_CHECK_EN
        // Case 6: compare against expected CRC
        crc_exp = 8'hF4;
        do_start(9'h107);
        send_msg(0, 8, 1'b1);
        wait_done("t6_done_ok");
        @(negedge clk);
        check("t6_err_match", {31'd0, crc_err}, 32'd0);
        crc_exp = 8'hF5;
        do_start(9'h107);
        send_msg(0, 8, 1'b1);
        wait_done("t6_done_bad");
        @(negedge clk);
        check("t6_err_set", {31'd0, crc_err}, 32'd1);
        repeat (3) @(negedge clk);
        check("t6_err_held", {31'd0, crc_err}, 32'd1);
        do_start(9'h107);
        check("t6_err_clear", {31'd0, crc_err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
